// File: rtl/seg7_frame_decoder.sv
// Decodes debounced active-low seven-segment digits into 16-bit words on a valid/ready output.
// Optional saturating illegal-pattern counter on err_count when SEG7_DEC_ERRCNT_EN is defined.
module seg7_frame_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [1:0]  digit_idx,
  input  logic        seg_valid,
  input  logic        word_ready,
  input  logic        clear_flags,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        err_pulse,
  output logic        overrun
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [6:0]  last_seg_q, last_seg_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  got_q, got_d;
  logic [15:0] word_q, word_d;
  logic        word_vld_q, word_vld_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;

  logic       same_sample;
  logic       accept;
  logic       legal;
  logic [3:0] nibble;
  logic [3:0] got_set;
  logic       frame_done;
  logic       xfer;
  logic       load;
  logic       drop;

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg_in)
      7'h40: nibble = 4'h0;
      7'h79: nibble = 4'h1;
      7'h24: nibble = 4'h2;
      7'h30: nibble = 4'h3;
      7'h19: nibble = 4'h4;
      7'h12: nibble = 4'h5;
      7'h02: nibble = 4'h6;
      7'h78: nibble = 4'h7;
      7'h00: nibble = 4'h8;
      7'h10: nibble = 4'h9;
      7'h08: nibble = 4'hA;
      7'h03: nibble = 4'hB;
      7'h46: nibble = 4'hC;
      7'h21: nibble = 4'hD;
      7'h06: nibble = 4'hE;
      7'h0E: nibble = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // Stability tracker: a run continues only while the same (pattern, index) keeps arriving.
  always_comb begin
    same_sample = (seg_in == last_seg_q) && (digit_idx == last_idx_q) && (cnt_q != 8'd0);
    last_seg_d  = last_seg_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    if (!seg_valid) begin
      cnt_d = 8'd0;
    end else if (same_sample) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end else begin
      last_seg_d = seg_in;
      last_idx_d = digit_idx;
      cnt_d      = 8'd1;
    end
    // A saturated run sitting at the threshold must not re-accept.
    accept = seg_valid && (cnt_d == STABLE_C) && !(same_sample && (cnt_q == STABLE_C));
  end

  always_comb begin
    digits_d = digits_q;
    got_set  = got_q;
    if (accept && legal) begin
      digits_d[{digit_idx, 2'b00} +: 4] = nibble;
      got_set[digit_idx]               = 1'b1;
    end
    frame_done = accept && legal && (got_set == 4'hF);
    got_d      = frame_done ? 4'h0 : got_set;

    xfer = word_vld_q && word_ready;
    load = frame_done && (!word_vld_q || word_ready);
    drop = frame_done && !load;

    word_d     = load ? digits_d : word_q;
    word_vld_d = load ? 1'b1 : (xfer ? 1'b0 : word_vld_q);
    err_d      = accept && !legal;
    ovr_d      = drop ? 1'b1 : (clear_flags ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seg_q <= 7'h7F;
      last_idx_q <= 2'd0;
      cnt_q      <= 8'd0;
      digits_q   <= 16'h0000;
      got_q      <= 4'h0;
      word_q     <= 16'h0000;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      last_seg_q <= last_seg_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      got_q      <= got_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A clear coinciding with an illegal accept leaves the count at one.
  always_comb begin
    err_cnt_d = clear_flags ? 8'd0 : err_cnt_q;
    if (err_d && (err_cnt_d != 8'hFF)) begin
      err_cnt_d = err_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign word_out   = word_q;
  assign word_valid = word_vld_q;
  assign err_pulse  = err_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Randomized and directed bench for seg7_frame_decoder against a run-length reference model.
module tb_seg7_frame_decoder;

  localparam int S = 4;
  localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [1:0]  digit_idx = 2'd0;
  logic        seg_valid = 1'b0;
  logic        word_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        err_pulse;
  logic        overrun;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [6:0]  m_seg;
  logic [1:0]  m_idx;
  int          m_run;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_got;
  logic [15:0] m_word;
  logic        m_wv;
  logic        m_err;
  logic        m_ovr;
  int          m_errcnt;

  seg7_frame_decoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .digit_idx  (digit_idx),
    .seg_valid  (seg_valid),
    .word_ready (word_ready),
    .clear_flags(clear_flags),
    .word_out   (word_out),
    .word_valid (word_valid),
    .err_pulse  (err_pulse),
    .overrun    (overrun)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (CODES[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_seg = 7'h7F; m_idx = 2'd0; m_run = 0; m_got = 4'h0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_word = 16'h0; m_wv = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_errcnt = 0;
  endtask

  // One clock edge of the specified behaviour, using plain run-length counting.
  task automatic model_step(input logic [6:0] s, input logic [1:0] idx, input logic vld,
                            input logic rdy, input logic clr);
    int  nib;
    bit  acc, xfer, load, drop;
    if (!vld) m_run = 0;
    else if (s == m_seg && idx == m_idx && m_run > 0) m_run++;
    else begin m_seg = s; m_idx = idx; m_run = 1; end
    acc  = vld && (m_run == S);
    nib  = decode(s);
    xfer = m_wv && rdy;
    load = 0; drop = 0;
    m_err = acc && (nib < 0);
    if (acc && nib >= 0) begin
      m_dig[idx] = nib[3:0];
      m_got[idx] = 1'b1;
      if (m_got == 4'hF) begin
        m_got = 4'h0;
        if (!m_wv || rdy) load = 1; else drop = 1;
      end
    end
    if (load) begin m_word = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}; m_wv = 1'b1; end
    else if (xfer) m_wv = 1'b0;
    if (clr) m_ovr = 1'b0;
    if (drop) m_ovr = 1'b1;
    if (clr) m_errcnt = 0;
    if (m_err && m_errcnt < 255) m_errcnt++;
  endtask

  task automatic cyc(input logic [6:0] s, input logic [1:0] idx, input logic vld,
                     input logic rdy, input logic clr);
    seg_in = s; digit_idx = idx; seg_valid = vld; word_ready = rdy; clear_flags = clr;
    model_step(s, idx, vld, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input logic [1:0] idx, input int n, input logic rdy);
    repeat (n) cyc(s, idx, 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(7'h7F, 2'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (word_out !== 16'h0000 || word_valid !== 1'b0 || err_pulse !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: word_out=%h word_valid=%b err_pulse=%b overrun=%b, want 0000 0 0 0",
               word_out, word_valid, err_pulse, overrun);
    end
`ifdef SEG7_DEC_ERRCNT_EN
    checks++;
    if (err_count !== 8'h00) begin
      errors++; $display("FAIL reset_errcnt: got %h want 00", err_count);
    end
`endif
  endtask

  task automatic test_basic_frame();
    hold(7'h40, 2'd0, 4, 1'b1);
    hold(7'h79, 2'd1, 4, 1'b1);
    hold(7'h24, 2'd2, 4, 1'b1);
    hold(7'h30, 2'd3, 3, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: word_valid=%b want 0", word_valid);
    end
    hold(7'h30, 2'd3, 1, 1'b1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'h3210) begin
      errors++; $display("FAIL basic_word: word_valid=%b word_out=%h want 1 3210", word_valid, word_out);
    end
    idle(1, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: word_valid=%b want 0", word_valid);
    end
  endtask

  task automatic test_gap_restart();
    hold(7'h02, 2'd0, 3, 1'b1);
    idle(1, 1'b1);
    hold(7'h02, 2'd0, 3, 1'b1);
    idle(1, 1'b1);
    hold(7'h79, 2'd1, 4, 1'b1);
    hold(7'h24, 2'd2, 4, 1'b1);
    hold(7'h30, 2'd3, 4, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL gap_no_accept: word_valid=%b want 0", word_valid);
    end
    hold(7'h02, 2'd0, 4, 1'b1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'h3216) begin
      errors++; $display("FAIL gap_accept: word_valid=%b word_out=%h want 1 3216", word_valid, word_out);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_illegal();
    hold(7'h7F, 2'd1, 3, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL illegal_early: err_pulse=%b want 0", err_pulse);
    end
    hold(7'h7F, 2'd1, 1, 1'b0);
    checks++;
    if (err_pulse !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse: err_pulse=%b want 1", err_pulse);
    end
`ifdef SEG7_DEC_ERRCNT_EN
    checks++;
    if (err_count !== 8'h01) begin
      errors++; $display("FAIL illegal_errcnt: got %h want 01", err_count);
    end
`endif
    hold(7'h7F, 2'd1, 1, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL illegal_once: err_pulse=%b want 0", err_pulse);
    end
    idle(1, 1'b1);
    hold(7'h40, 2'd0, 4, 1'b1);
    hold(7'h24, 2'd2, 4, 1'b1);
    hold(7'h30, 2'd3, 4, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_got_kept: word_valid=%b want 0", word_valid);
    end
    hold(7'h79, 2'd1, 4, 1'b1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'h3210) begin
      errors++; $display("FAIL illegal_then_word: word_valid=%b word_out=%h want 1 3210", word_valid, word_out);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_overrun();
    hold(7'h21, 2'd0, 4, 1'b0);
    hold(7'h46, 2'd1, 4, 1'b0);
    hold(7'h03, 2'd2, 4, 1'b0);
    hold(7'h08, 2'd3, 4, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'hABCD || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: wv=%b word=%h ovr=%b want 1 ABCD 0", word_valid, word_out, overrun);
    end
    hold(7'h79, 2'd0, 4, 1'b0);
    hold(7'h40, 2'd1, 4, 1'b0);
    hold(7'h0E, 2'd2, 4, 1'b0);
    hold(7'h06, 2'd3, 4, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'hABCD || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_drop: wv=%b word=%h ovr=%b want 1 ABCD 1", word_valid, word_out, overrun);
    end
    cyc(7'h7F, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || word_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_clear: ovr=%b wv=%b want 0 1", overrun, word_valid);
    end
    idle(1, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_drain: word_valid=%b want 0", word_valid);
    end
  endtask

  task automatic test_back_to_back();
    hold(7'h19, 2'd0, 4, 1'b0);
    hold(7'h30, 2'd1, 4, 1'b0);
    hold(7'h24, 2'd2, 4, 1'b0);
    hold(7'h79, 2'd3, 4, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'h1234) begin
      errors++; $display("FAIL b2b_first: wv=%b word=%h want 1 1234", word_valid, word_out);
    end
    hold(7'h00, 2'd0, 4, 1'b0);
    hold(7'h78, 2'd1, 4, 1'b0);
    hold(7'h02, 2'd2, 4, 1'b0);
    hold(7'h12, 2'd3, 3, 1'b0);
    cyc(7'h12, 2'd3, 1'b1, 1'b1, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 16'h5678 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_reload: wv=%b word=%h ovr=%b want 1 5678 0", word_valid, word_out, overrun);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    hold(7'h19, 2'd0, 4, 1'b0);
    hold(7'h30, 2'd1, 4, 1'b0);
    hold(7'h24, 2'd2, 4, 1'b0);
    hold(7'h79, 2'd3, 4, 1'b0);
    hold(7'h40, 2'd0, 4, 1'b0);
    hold(7'h79, 2'd1, 4, 1'b0);
    hold(7'h24, 2'd2, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (word_out !== 16'h0000 || word_valid !== 1'b0 || err_pulse !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: word=%h wv=%b err=%b ovr=%b want 0000 0 0 0",
               word_out, word_valid, err_pulse, overrun);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    idle(1, 1'b1);
    hold(7'h30, 2'd3, 4, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL reset_partial_discard: word_valid=%b want 0", word_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [6:0] prev = 7'h40;
    logic [1:0] idx;
    int cycles = 0;
    int sel;
    int len;
    while (cycles < 3000) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) s = CODES[$urandom_range(0, 15)];
      else if (sel == 7) s = 7'h7F;
      else if (sel == 8) s = 7'($urandom);
      else s = prev;
      prev = s;
      idx = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        cyc(s, idx, ($urandom_range(0, 11) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
        cycles++;
        checks++;
        if (word_out !== m_word || word_valid !== m_wv || err_pulse !== m_err || overrun !== m_ovr) begin
          errors++;
          $display("FAIL random_cycle%0d: word=%h wv=%b err=%b ovr=%b want %h %b %b %b",
                   cycles, word_out, word_valid, err_pulse, overrun, m_word, m_wv, m_err, m_ovr);
        end
`ifdef SEG7_DEC_ERRCNT_EN
        checks++;
        if (err_count !== 8'(m_errcnt)) begin
          errors++; $display("FAIL random_errcnt%0d: got %h want %h", cycles, err_count, 8'(m_errcnt));
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gap_restart();
    test_illegal();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
# seg7_frame_decoder

Receive-side companion to the hex-to-seven-segment encoder: it samples active-low seven-segment patterns with a digit index, debounces each digit, decodes it back to a 4-bit hex value, and assembles four digits into a 16-bit word. The output is a valid/ready handshake. It sits between a scanned display bus (or a loopback of our own display driver) and the datapath, and is used for self-test and front-panel readback.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical valid samples needed to accept a digit. Legal range is 1 to 255.

Ports:
- clk, input, 1: system clock. All state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- seg_in, input, 7: active-low segments, bit0=a … bit6=g. A 0 means the segment is lit.
- digit_idx, input, 2: digit position. 0 is the least-significant nibble.
- seg_valid, input, 1: seg_in and digit_idx are meaningful this cycle.
- word_ready, input, 1: consumer accepts word_out.
- clear_flags, input, 1: synchronous clear of overrun (and err_count when compiled in).
- word_out, output, 16: assembled word, {d3,d2,d1,d0}.
- word_valid, output, 1: word_out holds an unconsumed word.
- err_pulse, output, 1: one-cycle pulse when an illegal pattern is accepted as stable.
- overrun, output, 1: sticky. A completed frame was dropped.
- err_count, output, 8: present only with SEG7_DEC_ERRCNT_EN.

## Operation
- Legal codes (seg_in hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
- Every other code is illegal, including 7F (blank).
- Stability tracker registers: last_seg, last_idx, and an 8-bit count.
  - seg_valid=0: count←0.
  - seg_valid=1 and (seg_in,digit_idx) equal to (last_seg,last_idx) with count≠0: count←min(count+1, 255).
  - Any other seg_valid=1 cycle: last←inputs, count←1.
- Accept event: the edge on which count becomes exactly STABLE_CYCLES. It happens once per stable run; further identical samples do nothing.
  - Legal code: digit[idx]←nibble, got[idx]←1.
  - Illegal code: err_pulse=1 next cycle; digit and got unchanged.
- Re-accepting an already-got index overwrites that digit.
- Frame complete: an accept makes got all ones.
  - If word_valid=0, or word_ready=1 this cycle: word_out←{digits incl. new one}, word_valid←1, got←0.
  - Otherwise: frame dropped, word_out unchanged, overrun←1, got←0.
- Handshake: transfer occurs when word_valid and word_ready are both high. word_valid then falls unless a new frame completes on the same edge, in which case word_valid stays 1 with the new data and there is no overrun.
- word_out is stable while word_valid=1 and not transferred.
- clear_flags clears overrun on the next edge. A simultaneous set wins.

## Timing
- Reset values: word_out=0000, word_valid=0, err_pulse=0, overrun=0, err_count=0, got=0, count=0, last_seg=7F, last_idx=0, all digits=0.
- Reset is asynchronous at any point and discards partial frames and any pending word.
- Accept latency: a pattern presented from cycle t with seg_valid held is accepted on the edge ending cycle t+STABLE_CYCLES−1.
- The resulting digit write, err_pulse, or word_valid is visible in cycle t+STABLE_CYCLES.
- A single-cycle seg_valid gap restarts the count.
- With STABLE_CYCLES=1, every change of pattern or index is an accept.
- No combinational path from inputs to outputs.

## Configuration
- SEG7_DEC_ERRCNT_EN defined:
  - err_count port exists.
  - It increments (saturating at FF) on each illegal accept.
  - It is cleared by clear_flags; an increment on the same edge wins (count←1).
- Undefined: the port and counter are absent; err_pulse still works.

## Test plan
- STABLE_CYCLES=4; digits idx0=40, idx1=79, idx2=24, idx3=30, each held 4 cycles, word_ready=1 → word_out=3210, word_valid high for 1 cycle, in the cycle after the 4th sample of idx3.
- Idx0 pattern 02 held 3 cycles, then 1 cycle seg_valid=0, then 3 cycles → no accept. Holding 4 cycles then accepts 6.
- Illegal 7F held 4 cycles on idx1 → err_pulse once. err_count=01 when compiled in. got[1] unchanged.
- Frame ABCD completes with word_ready=0, then frame EF01 completes → word_out stays ABCD, overrun=1. Then clear_flags → overrun=0.
- word_valid=1 with word_ready=1 on the same edge that frame 5678 completes → new word loaded, word_valid stays 1, overrun=0.
- rst_n pulsed low after 3 digits accepted → all outputs at reset values immediately. A subsequent single digit produces no word.
